glyph_table_loader: RTL and testbench

- Writer side of the glyph table that the text display reads through its pixel lookup path.
- Accepts a byte stream (UART RX or host FIFO) over a valid/ready handshake and frames it into glyph records: header byte, ASCII code, 8 row bytes.
- Packs each pair of rows into the 16-bit glyph word format and issues single-cycle writes on the glyph table's spare write port.
- Lets fonts be replaced at run time without re-synthesising the memory init file.

---
 rtl/glyph_table_loader.sv | 149 ++++++++++++++
 tb/tb_glyph_table_loader.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/glyph_table_loader.sv
`default_nettype none
// ============================================================================
// Module   : glyph_table_loader
// Brief    : Frames a byte stream into glyph records and writes 16-bit row-pair
//            words into the glyph table's spare write port.
// Revision : 1.0
// ============================================================================
module glyph_table_loader #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter int         ADDR_W         = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              gt_we,
  output logic [ADDR_W-1:0] gt_addr,
  output logic [15:0]       gt_din,
  output logic              busy,
  output logic              glyph_done,
  output logic              frame_err,
  output logic [7:0]        glyph_count
);

  localparam int              TMO_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CODE   = 3'd1;
  localparam logic [2:0] S_ROW_HI = 3'd2;
  localparam logic [2:0] S_ROW_LO = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [7:0]        code_q;
  logic [7:0]        hi_q;
  logic [1:0]        k_q;
  logic [TMO_W-1:0]  tmo_q;
  logic [ADDR_W-1:0] gt_addr_q;
  logic [15:0]       gt_din_q;
  logic              done_q;
  logic              ferr_q;
  logic [7:0]        count_q;

  logic              accept;
  logic              counting;
  logic              tmo_hit;
  logic              last_word;
  logic [ADDR_W-1:0] word_addr;

  assign accept    = in_valid && in_ready;
  assign counting  = (state_q == S_CODE) || (state_q == S_ROW_HI) || (state_q == S_ROW_LO);
  assign tmo_hit   = counting && (tmo_q == TMO_LAST) && !accept;
  assign last_word = (state_q == S_WRITE) && (k_q == 2'd3);

  // {code, k} equals {code, 2'b00} + k since k never exceeds 3
  always_comb begin
    word_addr      = '0;
    word_addr[9:0] = {code_q, k_q};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept && (in_data == SYNC_BYTE)) state_d = S_CODE;
      end
      S_CODE: begin
        if (accept)       state_d = S_ROW_HI;
        else if (tmo_hit) state_d = S_IDLE;
      end
      S_ROW_HI: begin
        if (accept)       state_d = S_ROW_LO;
        else if (tmo_hit) state_d = S_IDLE;
      end
      S_ROW_LO: begin
        if (accept)       state_d = S_WRITE;
        else if (tmo_hit) state_d = S_IDLE;
      end
      S_WRITE: begin
        state_d = (k_q == 2'd3) ? S_IDLE : S_ROW_HI;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q != S_WRITE);
    gt_we    = (state_q == S_WRITE);
    busy     = (state_q != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      code_q    <= '0;
      hi_q      <= '0;
      k_q       <= '0;
      tmo_q     <= '0;
      gt_addr_q <= '0;
      gt_din_q  <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      done_q <= last_word;
      ferr_q <= tmo_hit;
      if (last_word) count_q <= count_q + 8'd1;

      // Counter is held at zero outside the record states so every entry starts fresh
      if (!counting || accept || tmo_hit) tmo_q <= '0;
      else                                tmo_q <= tmo_q + TMO_W'(1);

      if (accept) begin
        case (state_q)
          S_CODE: begin
            code_q <= in_data;
            k_q    <= 2'd0;
          end
          S_ROW_HI: hi_q <= in_data;
          S_ROW_LO: begin
            gt_din_q  <= {hi_q, in_data};
            gt_addr_q <= word_addr;
          end
          default: ;
        endcase
      end

      if ((state_q == S_WRITE) && (k_q != 2'd3)) k_q <= k_q + 2'd1;
    end
  end

  assign gt_addr     = gt_addr_q;
  assign gt_din      = gt_din_q;
  assign glyph_done  = done_q;
  assign frame_err   = ferr_q;
  assign glyph_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_glyph_table_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_glyph_table_loader
// Brief    : Directed self-checking bench for glyph_table_loader.
// Revision : 1.0
// ============================================================================
module tb_glyph_table_loader;

  localparam int AW = 13;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          gt_we;
  logic [AW-1:0] gt_addr;
  logic [15:0]   gt_din;
  logic          busy;
  logic          glyph_done;
  logic          frame_err;
  logic [7:0]    glyph_count;

  always #5 clk = ~clk;

  glyph_table_loader #(
    .SYNC_BYTE     (8'hA5),
    .TIMEOUT_CYCLES(16),
    .ADDR_W        (AW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .gt_we      (gt_we),
    .gt_addr    (gt_addr),
    .gt_din     (gt_din),
    .busy       (busy),
    .glyph_done (glyph_done),
    .frame_err  (frame_err),
    .glyph_count(glyph_count)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [15:0]   d;
    logic          rdy;
  } wr_t;

  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  int  done_cnt = 0;
  int  ferr_cnt = 0;
  int  last_wcyc = 0;
  int  done_cyc = 0;
  int  ferr_cyc = 0;
  wr_t wq[$];
  wr_t eq[$];

  always @(negedge clk) begin
    wr_t w;
    cyc++;
    if (gt_we === 1'b1) begin
      w.a = gt_addr;
      w.d = gt_din;
      w.rdy = in_ready;
      wq.push_back(w);
      last_wcyc = cyc;
    end
    if (glyph_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (frame_err === 1'b1) begin
      ferr_cnt++;
      ferr_cyc = cyc;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=expired expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) chk("send_bound", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rec(input logic [7:0] code, input logic [63:0] rows);
    send(8'hA5);
    send(code);
    for (int i = 0; i < 8; i++) send(rows[63-8*i -: 8]);
  endtask

  task automatic chk_rec(input string tag, input logic [AW-1:0] base, input logic [63:0] rows);
    chk({tag, "_nwr"}, 32'(wq.size()), 32'd4);
    if (wq.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        chk({tag, "_addr"}, 32'(wq[i].a), 32'(base + AW'(i)));
        chk({tag, "_din"},  32'(wq[i].d), 32'(rows[63-16*i -: 16]));
        chk({tag, "_rdy"},  32'(wq[i].rdy), 32'd0);
      end
    end
  endtask

  initial begin
    int d0, f0, bad;
    logic [7:0]  code;
    logic [63:0] rows;
    wr_t e;

    reset = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_we",    32'(gt_we), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(glyph_done), 32'd0);
    chk("rst_ferr",  32'(frame_err), 32'd0);
    chk("rst_cnt",   32'(glyph_count), 32'd0);
    chk("rst_addr",  32'(gt_addr), 32'd0);
    chk("rst_din",   32'(gt_din), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Record 'A' with valid held high throughout
    wq.delete();
    d0 = done_cnt;
    send_rec(8'h41, 64'h0018_2442_7E42_4200);
    idle(3);
    chk_rec("recA", 13'h104, 64'h0018_2442_7E42_4200);
    chk("recA_done",  32'(done_cnt - d0), 32'd1);
    chk("recA_dtime", 32'(done_cyc - last_wcyc), 32'd1);
    chk("recA_cnt",   32'(glyph_count), 32'd1);
    chk("recA_busy",  32'(busy), 32'd0);

    // Garbage before sync, then top-of-range codes
    wq.delete();
    send(8'h00); send(8'hFF); send(8'h13);
    send_rec(8'h7F, 64'h0102_0304_0506_0708);
    idle(2);
    chk_rec("rec7F", 13'h1FC, 64'h0102_0304_0506_0708);
    wq.delete();
    send_rec(8'hFF, 64'h80C0_E0F0_F8FC_FEFF);
    idle(2);
    chk_rec("recFF", 13'h3FC, 64'h80C0_E0F0_F8FC_FEFF);
    wq.delete();
    send_rec(8'hA5, 64'h5A5A_A5A5_0F0F_F0F0);
    idle(2);
    chk_rec("recA5", 13'h294, 64'h5A5A_A5A5_0F0F_F0F0);
    chk("cnt_after4", 32'(glyph_count), 32'd4);

    // Timeout after one word
    wq.delete();
    f0 = ferr_cnt;
    send(8'hA5); send(8'h20); send(8'h11); send(8'h22);
    idle(25);
    chk("tmo_nwr",  32'(wq.size()), 32'd1);
    if (wq.size() >= 1) begin
      chk("tmo_addr", 32'(wq[0].a), 32'h080);
      chk("tmo_din",  32'(wq[0].d), 32'h1122);
    end
    chk("tmo_ferr",  32'(ferr_cnt - f0), 32'd1);
    chk("tmo_ftime", 32'(ferr_cyc - last_wcyc), 32'd17);
    chk("tmo_busy",  32'(busy), 32'd0);
    chk("tmo_cnt",   32'(glyph_count), 32'd4);
    wq.delete();
    send_rec(8'h30, 64'h1234_5678_9ABC_DEF0);
    idle(2);
    chk_rec("recAfterTmo", 13'h0C0, 64'h1234_5678_9ABC_DEF0);
    chk("cnt_after5", 32'(glyph_count), 32'd5);

    // Byte arrives on the terminal-count cycle
    wq.delete();
    f0 = ferr_cnt;
    send(8'hA5); send(8'h21);
    idle(15);
    rows = 64'h1122_3344_5566_7788;
    for (int i = 0; i < 8; i++) send(rows[63-8*i -: 8]);
    idle(2);
    chk("term_ferr", 32'(ferr_cnt - f0), 32'd0);
    chk_rec("recTerm", 13'h084, rows);
    chk("cnt_after6", 32'(glyph_count), 32'd6);

    // Reset while waiting for the low row of word 2
    wq.delete();
    send(8'hA5); send(8'h42);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'h05);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy",  32'(busy), 32'd0);
    chk("rst_mid_ready", 32'(in_ready), 32'd1);
    chk("rst_mid_cnt",   32'(glyph_count), 32'd0);
    idle(5);
    chk("rst_mid_nwr",   32'(wq.size()), 32'd2);

    // 256 records with short random gaps against a reference list
    wq.delete();
    eq.delete();
    d0 = done_cnt;
    f0 = ferr_cnt;
    for (int r = 0; r < 256; r++) begin
      code = 8'($urandom_range(0, 255));
      rows = {$urandom, $urandom};
      for (int i = 0; i < 4; i++) begin
        e.a = AW'({code, 2'(i)});
        e.d = rows[63-16*i -: 16];
        e.rdy = 1'b0;
        eq.push_back(e);
      end
      idle($urandom_range(0, 4)); send(8'hA5);
      idle($urandom_range(0, 4)); send(code);
      for (int i = 0; i < 8; i++) begin
        idle($urandom_range(0, 4));
        send(rows[63-8*i -: 8]);
      end
    end
    idle(5);
    chk("bulk_nwr", 32'(wq.size()), 32'd1024);
    bad = 0;
    if (wq.size() == 1024) begin
      for (int i = 0; i < 1024; i++) if (wq[i] !== eq[i]) bad++;
    end
    chk("bulk_mismatches", 32'(bad), 32'd0);
    chk("bulk_cnt",  32'(glyph_count), 32'd0);
    chk("bulk_done", 32'(done_cnt - d0), 32'd256);
    chk("bulk_ferr", 32'(ferr_cnt - f0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
